fp_cmp_unit: RTL
================

// Module: fp_cmp_unit
// PURPOSE
//  Two-stage pipelined RV32F compare/min-max execute unit, downstream of the raw FP magnitude comparator (comp_block).
//  Registers operands, instantiates comp_block on them, then applies IEEE-754 corrections: both-negative swap, +/-0 and NaN.
//  Produces FEQ.S/FLT.S/FLE.S/FMIN.S/FMAX.S results plus the NV flag, with valid/ready on both sides.
// PARAMETERS
//  TAG_W   5            width of the destination-register tag carried alongside each op
//  CNAN    32'h7FC00000 canonical quiet NaN returned by FMIN/FMAX when both inputs are NaN
// PORTS
//  i_clk      in   1      clock, all state on rising edge
//  i_reset    in   1      synchronous active-high reset
//  i_valid    in   1      upstream op valid
//  o_ready    out  1      unit can accept op this cycle
//  i_op       in   3      000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX; others reserved
//  i_rs1_f    in   32     operand a (IEEE single)
//  i_rs2_f    in   32     operand b (IEEE single)
//  i_tag      in   TAG_W  destination tag
//  o_valid    out  1      result valid
//  i_ready    in   1      downstream accepts result
//  o_result   out  32     FEQ/FLT/FLE: {31'b0,bit}; FMIN/FMAX: selected operand or CNAN
//  o_fflags   out  5      {NV,DZ,OF,UF,NX}; only NV ever set, others always 0
//  o_tag      out  TAG_W  tag of the result
// BEHAVIOUR
//  Reset (i_reset=1 at edge): s1_valid=0, s2_valid=0, o_result=0, o_fflags=0, o_tag=0; in-flight ops discarded, none emitted.
//  o_ready=0 while i_reset is high, else o_ready = !s1_valid | s2_ready; s2_ready = !s2_valid | i_ready.
//  Accept on i_valid & o_ready: capture op/operands/tag into S1. S1 -> S2 when s1_valid & s2_ready.
//  o_valid = s2_valid; S2 holds o_result/o_fflags/o_tag stable until i_ready=1 (no change while stalled).
//  Latency 2 cycles accept->o_valid; throughput 1 op/cycle when i_ready held 1; full back-pressure stalls both stages.
//  Simultaneous accept and S2 drain in one cycle is legal; no bubble inserted.
//  S1 logic (combinational off S1 regs), comp_block gives raw gt/eq/lt of {S,E,M}:
//   - isnan = E==8'hFF & M!=0; issnan = isnan & !M[22]; iszero = E==0 & M==0.
//   - both zero (any signs): eq=1, gt=lt=0.
//   - Sa=Sb=1 and not both zero: swap raw gt/lt; eq unchanged.
//   - FEQ: res = eq & !nan_any; NV = snan_any.
//   - FLT: res = lt & !nan_any; FLE: res = (lt|eq) & !nan_any; NV = nan_any (signaling compare).
//   - FMIN/FMAX: both NaN -> CNAN; one NaN -> other operand; else min/max by corrected lt/gt,
//     with -0 treated less than +0 (FMIN(+0,-0)=80000000, FMAX=00000000); NV = snan_any.
//   - reserved op: o_result=0, o_fflags=0, still flows through pipeline normally.
//  Input operands/op sampled only on accept; upstream changes while o_ready=0 have no effect.
// TESTING
//  FLT 3F800000(1.0) vs 40000000(2.0), i_ready=1 -> o_valid 2 cycles after accept, o_result=1, o_fflags=0.
//  FLT BF800000(-1.0) vs C0000000(-2.0) -> o_result=0; FLE same swapped -> 1 (both-negative swap).
//  FEQ 00000000 vs 80000000 -> 1; FMIN same -> 80000000; FMAX -> 00000000; fflags 0.
//  FEQ 7FC00000 vs 3F800000 -> 0, NV=0; FLT same -> 0, fflags=5'b10000; FMAX 7F800001 vs 3F800000 -> 3F800000, NV=1.
//  FMIN 7FC00000 vs 7F800001 -> CNAN, NV=1; 4 back-to-back ops with i_ready=0 for 3 cycles -> o_ready drops after 2 accepts, order/tags preserved.
//  Assert i_reset with both stages full -> next cycle o_valid=0, o_result=0; first post-reset op returns correctly 2 cycles later.

Source files
------------

// File: rtl/fp_cmp_unit.sv
// rtl/fp_cmp_unit.sv - two-stage RV32F compare/min-max execute unit
//
// comp_block: raw comparator on {S,E,M}. Opposite signs order by sign bit,
//   equal signs order by magnitude {E,M}. Negative-pair and zero handling is
//   left to the caller.
//   i_a, i_b      operand bit patterns
//   o_gt/eq/lt    raw relation of i_a to i_b
//
// fp_cmp_unit: FEQ.S/FLT.S/FLE.S/FMIN.S/FMAX.S with NV flag, valid/ready on
//   both sides. Stage 1 registers the op; stage 2 registers the result.
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_valid/o_ready         upstream handshake
//   i_op, i_rs1_f, i_rs2_f  operation and operands
//   i_tag                   destination tag carried with the op
//   o_valid/i_ready         downstream handshake
//   o_result, o_fflags      result word and {NV,DZ,OF,UF,NX}
//   o_tag                   tag of the result

module comp_block (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_gt,
  output logic        o_eq,
  output logic        o_lt
);
  always_comb begin
    o_gt = 1'b0;
    o_eq = 1'b0;
    o_lt = 1'b0;
    if (i_a == i_b) begin
      o_eq = 1'b1;
    end else if (i_a[31] != i_b[31]) begin
      o_gt = i_b[31];
      o_lt = i_a[31];
    end else if (i_a[30:0] > i_b[30:0]) begin
      o_gt = 1'b1;
    end else begin
      o_lt = 1'b1;
    end
  end
endmodule

module fp_cmp_unit #(
  parameter int          TAG_W = 5,
  parameter logic [31:0] CNAN  = 32'h7FC00000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [31:0]      i_rs1_f,
  input  logic [31:0]      i_rs2_f,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_result,
  output logic [4:0]       o_fflags,
  output logic [TAG_W-1:0] o_tag
);
  localparam logic [2:0] OP_FEQ  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FLE  = 3'b010;
  localparam logic [2:0] OP_FMIN = 3'b011;
  localparam logic [2:0] OP_FMAX = 3'b100;

  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic [31:0]      r_s1_a;
  logic [31:0]      r_s1_b;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [31:0]      r_result;
  logic [4:0]       r_fflags;
  logic [TAG_W-1:0] r_tag;

  logic w_s2_ready;
  logic w_accept;
  logic w_advance;

  assign w_s2_ready = !r_s2_valid || i_ready;
  assign o_ready    = !i_reset && (!r_s1_valid || w_s2_ready);
  assign w_accept   = i_valid && o_ready;
  assign w_advance  = r_s1_valid && w_s2_ready;

  assign o_valid  = r_s2_valid;
  assign o_result = r_result;
  assign o_fflags = r_fflags;
  assign o_tag    = r_tag;

  // Stage-1 classification and corrected relation
  logic w_raw_gt, w_raw_eq, w_raw_lt;
  logic w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_zero, w_b_zero;
  logic w_nan_any, w_snan_any, w_both_zero, w_both_neg;
  logic w_gt, w_eq, w_lt;
  logic [31:0] w_res;
  logic        w_nv;

  comp_block u_comp (
    .i_a  (r_s1_a),
    .i_b  (r_s1_b),
    .o_gt (w_raw_gt),
    .o_eq (w_raw_eq),
    .o_lt (w_raw_lt)
  );

  assign w_a_nan  = (r_s1_a[30:23] == 8'hFF) && (r_s1_a[22:0] != 23'd0);
  assign w_b_nan  = (r_s1_b[30:23] == 8'hFF) && (r_s1_b[22:0] != 23'd0);
  assign w_a_snan = w_a_nan && !r_s1_a[22];
  assign w_b_snan = w_b_nan && !r_s1_b[22];
  assign w_a_zero = (r_s1_a[30:0] == 31'd0);
  assign w_b_zero = (r_s1_b[30:0] == 31'd0);

  assign w_nan_any   = w_a_nan || w_b_nan;
  assign w_snan_any  = w_a_snan || w_b_snan;
  assign w_both_zero = w_a_zero && w_b_zero;
  assign w_both_neg  = r_s1_a[31] && r_s1_b[31];

  always_comb begin
    w_gt = w_raw_gt;
    w_eq = w_raw_eq;
    w_lt = w_raw_lt;
    if (w_both_zero) begin
      w_gt = 1'b0;
      w_eq = 1'b1;
      w_lt = 1'b0;
    end else if (w_both_neg) begin
      // larger magnitude is the smaller value when both are negative
      w_gt = w_raw_lt;
      w_lt = w_raw_gt;
    end
  end

  always_comb begin
    w_res = 32'd0;
    w_nv  = 1'b0;
    case (r_s1_op)
      OP_FEQ: begin
        w_res = {31'd0, w_eq && !w_nan_any};
        w_nv  = w_snan_any;
      end
      OP_FLT: begin
        w_res = {31'd0, w_lt && !w_nan_any};
        w_nv  = w_nan_any;
      end
      OP_FLE: begin
        w_res = {31'd0, (w_lt || w_eq) && !w_nan_any};
        w_nv  = w_nan_any;
      end
      OP_FMIN, OP_FMAX: begin
        w_nv = w_snan_any;
        if (w_a_nan && w_b_nan) begin
          w_res = CNAN;
        end else if (w_a_nan) begin
          w_res = r_s1_b;
        end else if (w_b_nan) begin
          w_res = r_s1_a;
        end else if (w_both_zero) begin
          // -0 orders below +0 for min/max even though they compare equal
          if (r_s1_op == OP_FMIN) begin
            w_res = r_s1_a[31] ? r_s1_a : r_s1_b;
          end else begin
            w_res = r_s1_a[31] ? r_s1_b : r_s1_a;
          end
        end else if (r_s1_op == OP_FMIN) begin
          w_res = w_lt ? r_s1_a : r_s1_b;
        end else begin
          w_res = w_gt ? r_s1_a : r_s1_b;
        end
      end
      default: begin
        w_res = 32'd0;
        w_nv  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= 3'd0;
      r_s1_a     <= 32'd0;
      r_s1_b     <= 32'd0;
      r_s1_tag   <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= i_op;
      r_s1_a     <= i_rs1_f;
      r_s1_b     <= i_rs2_f;
      r_s1_tag   <= i_tag;
    end else if (w_advance) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s2_valid <= 1'b0;
      r_result   <= 32'd0;
      r_fflags   <= 5'd0;
      r_tag      <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_res;
        r_fflags <= {w_nv, 4'b0000};
        r_tag    <= r_s1_tag;
      end
    end
  end
endmodule
